// File: rtl/led_cmd_framebuf_if.sv
// ---------------------------------------------------------------------------
// led_cmd_framebuf_if
// Bundles the command input and the LED matrix outputs of led_cmd_framebuf.
//   LED_CMD    10  command word from game logic ([9]=red [8]=green [7]=rsvd
//                  [6:3]=row [2:0]=column; [9:8]==0 is idle)
//   ROW_OUT    16  one-hot row drive, active-high
//   COL_R       8  red column drive for the current row
//   COL_G       8  green column drive for the current row
//   FRAME_SYNC  1  one-cycle pulse on each buffer swap
//   ERR_CNT     8  saturating count of discarded malformed words
// master: the game/board side (drives LED_CMD, observes matrix pins)
// slave : the frame buffer itself
// ---------------------------------------------------------------------------
interface led_cmd_framebuf_if;
    logic [9:0]  LED_CMD;
    logic [15:0] ROW_OUT;
    logic [7:0]  COL_R;
    logic [7:0]  COL_G;
    logic        FRAME_SYNC;
    logic [7:0]  ERR_CNT;

    modport master (
        output LED_CMD,
        input  ROW_OUT, COL_R, COL_G, FRAME_SYNC, ERR_CNT
    );

    modport slave (
        input  LED_CMD,
        output ROW_OUT, COL_R, COL_G, FRAME_SYNC, ERR_CNT
    );
endinterface

// File: rtl/led_cmd_framebuf.sv
// ---------------------------------------------------------------------------
// led_cmd_framebuf
// Collects LED command words into a 16x8 two-colour back buffer, copies it to
// a front buffer once per frame and scans the front buffer onto a
// row-multiplexed LED matrix, blanking the columns at the start of each row
// slot to hide ghosting from the previous row.
// Ports:
//   CLK  system clock
//   RST  asynchronous reset, active-high
//   bus  led_cmd_framebuf_if.slave (LED_CMD in; ROW_OUT, COL_R, COL_G,
//        FRAME_SYNC, ERR_CNT out, all registered)
// ---------------------------------------------------------------------------
module led_cmd_framebuf #(
    parameter int unsigned FRAME_CYCLES = 262144,
    parameter int unsigned ROW_CYCLES   = 2048,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic               CLK,
    input  logic               RST,
    led_cmd_framebuf_if.slave  bus
);

    localparam logic [19:0] FRAME_LAST = 20'(FRAME_CYCLES - 1);
    localparam logic [11:0] ROW_LAST   = 12'(ROW_CYCLES - 1);
    localparam logic [11:0] BLANK_LIM  = 12'(BLANK_CYCLES);

    // timers
    logic [19:0] frame_timer_reg;
    logic [11:0] row_timer_reg;
    logic [3:0]  row_idx_reg;

    // buffers, one byte per row and colour plane
    logic [7:0] back_r_reg  [16];
    logic [7:0] back_g_reg  [16];
    logic [7:0] front_r_reg [16];
    logic [7:0] front_g_reg [16];
    logic [7:0] back_r_next [16];
    logic [7:0] back_g_next [16];
    logic [7:0] front_r_next[16];
    logic [7:0] front_g_next[16];

    // registered outputs
    logic [15:0] row_out_reg;
    logic [7:0]  col_r_reg;
    logic [7:0]  col_g_reg;
    logic        frame_sync_reg;
    logic [7:0]  err_cnt_reg;

    // command decode
    logic       cmd_red;
    logic       cmd_green;
    logic       cmd_active;
    logic       cmd_err;
    logic       cmd_wr;
    logic [3:0] cmd_row;
    logic [7:0] cmd_mask;
    logic       frame_end;
    logic       row_end;

    assign cmd_red    = bus.LED_CMD[9];
    assign cmd_green  = bus.LED_CMD[8];
    assign cmd_active = cmd_red | cmd_green;
    assign cmd_err    = cmd_active & bus.LED_CMD[7];
    assign cmd_wr     = cmd_active & ~bus.LED_CMD[7];
    assign cmd_row    = bus.LED_CMD[6:3];
    assign cmd_mask   = 8'd1 << bus.LED_CMD[2:0];
    assign frame_end  = (frame_timer_reg == FRAME_LAST);
    assign row_end    = (row_timer_reg == ROW_LAST);

    // Per-row next-state. On the swap edge the back row restarts from zero, so
    // a command sampled on that edge lands only in the new back buffer.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_row
            logic       row_hit;
            logic [7:0] set_r;
            logic [7:0] set_g;
            logic [7:0] base_r;
            logic [7:0] base_g;

            assign row_hit = cmd_wr && (cmd_row == 4'(gi));
            assign set_r   = (row_hit && cmd_red)   ? cmd_mask : 8'd0;
            assign set_g   = (row_hit && cmd_green) ? cmd_mask : 8'd0;
            assign base_r  = frame_end ? 8'd0 : back_r_reg[gi];
            assign base_g  = frame_end ? 8'd0 : back_g_reg[gi];

            assign back_r_next[gi]  = base_r | set_r;
            assign back_g_next[gi]  = base_g | set_g;
            assign front_r_next[gi] = frame_end ? back_r_reg[gi] : front_r_reg[gi];
            assign front_g_next[gi] = frame_end ? back_g_reg[gi] : front_g_reg[gi];
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                back_r_reg[i]  <= 8'd0;
                back_g_reg[i]  <= 8'd0;
                front_r_reg[i] <= 8'd0;
                front_g_reg[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                back_r_reg[i]  <= back_r_next[i];
                back_g_reg[i]  <= back_g_next[i];
                front_r_reg[i] <= front_r_next[i];
                front_g_reg[i] <= front_g_next[i];
            end
        end
    end

    // Frame and row timers run freely and independently of each other.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_timer_reg <= 20'd0;
            row_timer_reg   <= 12'd0;
            row_idx_reg     <= 4'd0;
        end else begin
            frame_timer_reg <= frame_end ? 20'd0 : frame_timer_reg + 20'd1;
            row_timer_reg   <= row_end ? 12'd0 : row_timer_reg + 12'd1;
            if (row_end) begin
                row_idx_reg <= row_idx_reg + 4'd1;
            end
        end
    end

    // Scan outputs read the front buffer as it stands, so a swap shows up on
    // the very next non-blank cycle of whatever row is being driven.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_out_reg    <= 16'd0;
            col_r_reg      <= 8'd0;
            col_g_reg      <= 8'd0;
            frame_sync_reg <= 1'b0;
            err_cnt_reg    <= 8'd0;
        end else begin
            row_out_reg    <= 16'd1 << row_idx_reg;
            frame_sync_reg <= frame_end;
            if (row_timer_reg < BLANK_LIM) begin
                col_r_reg <= 8'd0;
                col_g_reg <= 8'd0;
            end else begin
                col_r_reg <= front_r_reg[row_idx_reg];
                col_g_reg <= front_g_reg[row_idx_reg];
            end
            if (cmd_err && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign bus.ROW_OUT    = row_out_reg;
    assign bus.COL_R      = col_r_reg;
    assign bus.COL_G      = col_g_reg;
    assign bus.FRAME_SYNC = frame_sync_reg;
    assign bus.ERR_CNT    = err_cnt_reg;

endmodule
